// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared riscv_core constants and PC classification types
package fetch_unit_pkg;

    localparam logic [31:0] RV_RESET_PC = 32'h4000_0000;
    localparam logic [3:0]  RV_BIOS_NIB = 4'h4;
    localparam logic [3:0]  RV_IMEM_NIB = 4'h1;
    localparam logic [31:0] RV_NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic is_bios;
        logic is_imem;
        logic misaligned;
    } pc_class_t;

    function automatic logic pc_is_bad(input pc_class_t cls);
        return cls.misaligned | ~(cls.is_bios | cls.is_imem);
    endfunction

endpackage

// File: rtl/fetch_addr_decode.sv
// rtl/fetch_addr_decode.sv - classifies a PC as BIOS, IMEM and/or misaligned
module fetch_addr_decode
    import fetch_unit_pkg::*;
#(
    parameter logic [3:0] BIOS_NIB = RV_BIOS_NIB,
    parameter logic [3:0] IMEM_NIB = RV_IMEM_NIB
) (
    input  logic [3:0] pc_nib_i,
    input  logic [1:0] pc_lo_i,
    output pc_class_t  cls_o
);

    always_comb begin
        cls_o.is_bios    = (pc_nib_i == BIOS_NIB);
        cls_o.is_imem    = (pc_nib_i == IMEM_NIB);
        cls_o.misaligned = |pc_lo_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, redirect flush and instruction steering for riscv_core
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RV_RESET_PC,
    parameter int          BIOS_AW      = 12,
    parameter int          IMEM_AW      = 14,
    parameter logic [3:0]  BIOS_NIB     = RV_BIOS_NIB,
    parameter logic [3:0]  IMEM_NIB     = RV_IMEM_NIB,
    parameter logic [31:0] NOP_INST     = RV_NOP_INST,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               dec_ready,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        bios_dout,
    input  logic [31:0]        imem_dout,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               inst_valid,
    output logic               fetch_fault
);

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    pc_class_t   cls;
    logic        fault;
    logic        adv;
    logic [31:0] src_word;

    fetch_addr_decode #(
        .BIOS_NIB (BIOS_NIB),
        .IMEM_NIB (IMEM_NIB)
    ) u_addr_decode (
        .pc_nib_i (pc_q[31:28]),
        .pc_lo_i  (pc_q[1:0]),
        .cls_o    (cls)
    );

    assign fault = vld_q & pc_is_bad(cls);
    assign adv   = vld_q & (flush_cnt_q == 2'd0) & ~fault & dec_ready;

    always_comb begin
        pc_d        = pc_q;
        vld_d       = 1'b1;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            pc_d        = RESET_PC;
            vld_d       = 1'b0;
            flush_cnt_d = 2'd0;
        end else if (redirect_valid) begin
            pc_d        = redirect_pc;
            flush_cnt_d = FLUSH_RELOAD;
        end else begin
            if (flush_cnt_q != 2'd0) begin
                flush_cnt_d = flush_cnt_q - 2'd1;
            end
            if (adv) begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            vld_q       <= 1'b0;
            flush_cnt_q <= 2'd0;
        end else begin
            pc_q        <= pc_d;
            vld_q       <= vld_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Memories return data one cycle later, so they are addressed with the PC about to be loaded.
    assign bios_addr = pc_d[BIOS_AW+1:2];
    assign imem_addr = pc_d[IMEM_AW+1:2];

    // Redirect kills the current word in the same cycle so a wrong-path instruction never reaches decode.
    assign inst_valid  = vld_q & (flush_cnt_q == 2'd0) & ~fault & ~redirect_valid;
    assign src_word    = cls.is_bios ? bios_dout : imem_dout;
    assign inst        = inst_valid ? src_word : NOP_INST;
    assign inst_pc     = pc_q;
    assign fetch_fault = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit with FLUSH_CYCLES of 1 and 3
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;

    logic [11:0] bios_addr1, bios_addr3;
    logic [13:0] imem_addr1, imem_addr3;
    logic [31:0] bios_dout1, bios_dout3, imem_dout1, imem_dout3;
    logic [31:0] inst1, inst3, inst_pc1, inst_pc3;
    logic        inst_valid1, inst_valid3, fetch_fault1, fetch_fault3;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] bios_word(input logic [11:0] a);
        return 32'hB105_0000 ^ {20'h0, a};
    endfunction

    function automatic logic [31:0] imem_word(input logic [13:0] a);
        return 32'h1E0E_0000 ^ {18'h0, a};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        case (pc[31:28])
            4'h4:    return bios_word(pc[13:2]);
            4'h1:    return imem_word(pc[15:2]);
            default: return 32'h0000_0013;
        endcase
    endfunction

    always @(posedge clk) begin
        bios_dout1 <= bios_word(bios_addr1);
        imem_dout1 <= imem_word(imem_addr1);
        bios_dout3 <= bios_word(bios_addr3);
        imem_dout3 <= imem_word(imem_addr3);
    end

    fetch_unit #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .bios_addr(bios_addr1), .imem_addr(imem_addr1),
        .bios_dout(bios_dout1), .imem_dout(imem_dout1), .inst(inst1), .inst_pc(inst_pc1),
        .inst_valid(inst_valid1), .fetch_fault(fetch_fault1)
    );

    fetch_unit #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .bios_addr(bios_addr3), .imem_addr(imem_addr3),
        .bios_dout(bios_dout3), .imem_dout(imem_dout3), .inst(inst3), .inst_pc(inst_pc3),
        .inst_valid(inst_valid3), .fetch_fault(fetch_fault3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs, then retire any instruction decode accepts this cycle.
    task automatic sample();
        logic [31:0] pc_exp;
        #1;
        if (inst_valid1 === 1'b1 && dec_ready === 1'b1) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected: observed pc %h expected no accept", inst_pc1);
            end
            if (exp_q.size() != 0) begin
                pc_exp = exp_q.pop_front();
                chk("sb_pc", inst_pc1, pc_exp);
                chk("sb_inst", inst1, exp_inst(pc_exp));
            end
        end
    endtask

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
        cyc(); cyc();
        sample();
        chk("rst_valid", {31'h0, inst_valid1}, 32'd0);
        chk("rst_fault", {31'h0, fetch_fault1}, 32'd0);
        chk("rst_inst", inst1, 32'h0000_0013);
        chk("rst_pc", inst_pc1, 32'h4000_0000);

        rst = 1'b0;
        sample();
        chk("rel_valid0", {31'h0, inst_valid1}, 32'd0);
        chk("rel_bios_addr0", {20'h0, bios_addr1}, 32'd0);

        exp_q.push_back(32'h4000_0000);
        cyc(); sample();
        chk("rel_valid1", {31'h0, inst_valid1}, 32'd1);
        chk("rel_bios_addr1", {20'h0, bios_addr1}, 32'd1);
        exp_q.push_back(32'h4000_0004);
        cyc(); sample();

        cyc(); dec_ready = 1'b0; sample();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin cyc(); sample(); end
            chk("stall_pc", inst_pc1, 32'h4000_0008);
            chk("stall_inst", inst1, bios_word(12'd2));
            chk("stall_bios_addr", {20'h0, bios_addr1}, 32'd2);
        end
        cyc(); dec_ready = 1'b1;
        exp_q.push_back(32'h4000_0008);
        sample();
        exp_q.push_back(32'h4000_000C);
        cyc(); sample();
        chk("post_stall_pc", inst_pc1, 32'h4000_000C);

        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h1000_0010; sample();
        chk("redir_inst", inst1, 32'h0000_0013);
        chk("redir_valid", {31'h0, inst_valid1}, 32'd0);
        chk("redir_imem_addr", {18'h0, imem_addr1}, 32'd4);
        chk("f3_valid_c0", {31'h0, inst_valid3}, 32'd0);
        exp_q.push_back(32'h1000_0010);
        cyc(); redirect_valid = 1'b0; sample();
        chk("redir_tgt_pc", inst_pc1, 32'h1000_0010);
        chk("f3_valid_c1", {31'h0, inst_valid3}, 32'd0);
        exp_q.push_back(32'h1000_0014);
        cyc(); sample();
        chk("f3_valid_c2", {31'h0, inst_valid3}, 32'd0);
        chk("f3_pc_hold", inst_pc3, 32'h1000_0010);
        exp_q.push_back(32'h1000_0018);
        cyc(); sample();
        chk("f3_valid_c3", {31'h0, inst_valid3}, 32'd1);
        chk("f3_pc", inst_pc3, 32'h1000_0010);
        chk("f3_inst", inst3, imem_word(14'd4));

        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h1000_0002; sample();
        cyc(); redirect_valid = 1'b0; sample();
        chk("mis_fault", {31'h0, fetch_fault1}, 32'd1);
        chk("mis_inst", inst1, 32'h0000_0013);
        chk("mis_valid", {31'h0, inst_valid1}, 32'd0);
        chk("mis_pc", inst_pc1, 32'h1000_0002);
        cyc(); sample();
        chk("mis_pc_frozen", inst_pc1, 32'h1000_0002);
        chk("mis_imem_addr", {18'h0, imem_addr1}, 32'd0);

        redirect_valid = 1'b1; redirect_pc = 32'h2000_0000; sample();
        cyc(); redirect_valid = 1'b0; sample();
        chk("unmap_fault", {31'h0, fetch_fault1}, 32'd1);
        chk("unmap_pc", inst_pc1, 32'h2000_0000);
        chk("unmap_inst", inst1, 32'h0000_0013);

        redirect_valid = 1'b1; redirect_pc = 32'h4000_0000; sample();
        chk("clr_fault_before", {31'h0, fetch_fault1}, 32'd1);
        exp_q.push_back(32'h4000_0000);
        cyc(); redirect_valid = 1'b0; sample();
        chk("clr_fault_after", {31'h0, fetch_fault1}, 32'd0);
        chk("clr_valid", {31'h0, inst_valid1}, 32'd1);

        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h4000_4000; sample();
        chk("wrap_bios_addr", {20'h0, bios_addr1}, 32'd0);
        exp_q.push_back(32'h4000_4000);
        cyc(); redirect_valid = 1'b0; sample();
        chk("wrap_fault", {31'h0, fetch_fault1}, 32'd0);
        chk("wrap_inst", inst1, bios_word(12'd0));

        cyc(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1000_0000; dec_ready = 1'b0;
        sample();
        cyc(); sample();
        chk("rst_pri_pc", inst_pc1, 32'h4000_0000);
        chk("rst_pri_valid", {31'h0, inst_valid1}, 32'd0);
        chk("rst_pri_inst", inst1, 32'h0000_0013);
        chk("rst_pri_pc3", inst_pc3, 32'h4000_0000);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
